aq_div_arbiter: RTL

//  Shares one 8-stage pipelined 24/16 -> 8-bit divider (aq_div24x16, instantiated inside) among
//  NUM_REQ requesters. Round-robin issue of at most one division per clock.

---
 rtl/aq_div_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aq_div_arbiter.sv
// rtl/aq_div_arbiter.sv - round-robin arbiter sharing one 8-stage pipelined 24/16 divider
// Optional divide-by-zero flagging is enabled by defining AQ_DIVARB_DIV0_EN.

module aq_div24x16 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_dina,
  input  logic [15:0] i_dinb,
  output logic [7:0]  o_dout
);

  // Restoring division, one quotient bit per stage, MSB first.
  for (genvar s = 0; s < 8; s++) begin : g_stage
    logic [23:0] w_rem_in;
    logic [15:0] w_dvs_in;
    logic [7:0]  w_quo_in;
    logic [23:0] w_sub;
    logic        w_ge;
    logic [7:0]  r_quo;

    if (s == 0) begin : g_head
      assign w_rem_in = i_dina;
      assign w_dvs_in = i_dinb;
      assign w_quo_in = '0;
    end else begin : g_body
      assign w_rem_in = g_stage[s-1].g_carry.r_rem;
      assign w_dvs_in = g_stage[s-1].g_carry.r_dvs;
      assign w_quo_in = g_stage[s-1].r_quo;
    end

    assign w_sub = {8'd0, w_dvs_in} << (7 - s);
    assign w_ge  = (w_rem_in >= w_sub);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_quo <= '0;
      end else begin
        r_quo <= w_ge ? (w_quo_in | (8'd1 << (7 - s))) : w_quo_in;
      end
    end

    if (s < 7) begin : g_carry
      logic [23:0] r_rem;
      logic [15:0] r_dvs;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rem <= '0;
          r_dvs <= '0;
        end else begin
          r_rem <= w_ge ? (w_rem_in - w_sub) : w_rem_in;
          r_dvs <= w_dvs_in;
        end
      end
    end
  end

  assign o_dout = g_stage[7].r_quo;

endmodule

module aq_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*24-1:0] i_req_dina,
  input  logic [NUM_REQ*16-1:0] i_req_dinb,
  output logic                  o_res_valid,
  output logic [ID_W-1:0]       o_res_id,
  output logic [7:0]            o_res_quo,
  output logic                  o_res_div0,
  output logic                  o_busy
);

  localparam logic [ID_W-1:0] LP_LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] r_ptr;
  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt_id;
  int              v_idx;
  logic [23:0]     w_dina;
  logic [15:0]     w_dinb;
  logic [7:0]      w_dout;
  logic [7:0]      r_tag_vld;
  logic [ID_W-1:0] r_tag_id [0:7];
  logic [3:0]      r_cnt;

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    v_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_gnt_vld && i_req_valid[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = v_idx[ID_W-1:0];
      end
    end
    w_gnt_vld = w_gnt_vld & i_en;
  end

  always_comb begin
    o_req_ready           = '0;
    o_req_ready[w_gnt_id] = w_gnt_vld;
  end

  assign w_dina = w_gnt_vld ? i_req_dina[24*w_gnt_id +: 24] : 24'd0;
  assign w_dinb = w_gnt_vld ? i_req_dinb[16*w_gnt_id +: 16] : 16'd0;

  aq_div24x16 u_div (
    .i_clk   (i_clk),
    .i_rst_n (~i_rst),
    .i_dina  (w_dina),
    .i_dinb  (w_dinb),
    .o_dout  (w_dout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_id == LP_LAST) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Tag pipe runs in lockstep with the divider stages.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      for (int i = 0; i < 8; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[6:0], w_gnt_vld};
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < 8; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

`ifdef AQ_DIVARB_DIV0_EN
  logic [7:0] r_tag_div0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_div0 <= '0;
      o_res_div0 <= 1'b0;
    end else begin
      r_tag_div0 <= {r_tag_div0[6:0], w_gnt_vld & (w_dinb == 16'd0)};
      o_res_div0 <= r_tag_div0[7];
    end
  end
`else
  assign o_res_div0 = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_res_valid <= 1'b0;
      o_res_id    <= '0;
      o_res_quo   <= '0;
    end else begin
      o_res_valid <= r_tag_vld[7];
      o_res_id    <= r_tag_id[7];
`ifdef AQ_DIVARB_DIV0_EN
      o_res_quo   <= r_tag_div0[7] ? 8'hFF : w_dout;
`else
      o_res_quo   <= w_dout;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_gnt_vld, o_res_valid})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_busy = (r_cnt != 4'd0);

endmodule
